// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment scan controller:
//   - NIBBLE_W          : width of one BCD digit in the packed display word
//   - SEG_0..SEG_9      : segment patterns, bit 6 = segment a ... bit 0 = segment g
//   - SEG_BLANK         : all segments off
//   - state_t           : scan FSM state encoding (STATE_BLANK, STATE_SHOW)
//   - max2()            : integer maximum, used for parameter-derived widths
package seg7_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Scan FSM states. Kept as plain constants so the encoding is fixed
    // and visible on the debug state output.
    typedef logic [0:0] state_t;
    localparam state_t STATE_BLANK = 1'b0;
    localparam state_t STATE_SHOW  = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational BCD to seven-segment decoder. Codes 10..15 decode to blank.
// Ports:
//   nibble   in  4  BCD digit
//   segments out 7  active-high segment pattern, bit 6 = a ... bit 0 = g
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [6:0]          segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (nibble)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
// Time-multiplexed scan controller for a common-segment seven-segment display.
// Each digit gets BLANK_CYCLES all-off cycles followed by SCAN_DIV lit cycles.
// A new word is taken into a shadow register through a valid/ready handshake
// and copied into the displayed word only at the end of a frame, so a frame
// never shows a mix of old and new digits.
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits (digit 0 is never blanked). Default build shows every digit.
//
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both high. load_ready is low while a word waits for commit;
// load_valid may drop at any time, and nothing happens unless both are high.
//
// Ports:
//   clk          in   1             system clock
//   reset        in   1             synchronous active-high reset
//   load_valid   in   1             new display word offered
//   load_digits  in   4*NUM_DIGITS  packed BCD word, nibble i -> digit i
//   load_ready   out  1             a word can be accepted
//   led_out      out  7             segment drive, bit 6 = a ... bit 0 = g
//   digit_en     out  NUM_DIGITS    one-hot digit enable, zero while blanking
//   frame_done   out  1             pulse on the last lit cycle of the top digit
//   scan_state   out  1             current FSM state (debug)
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 16000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_valid,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_digits,
    output logic                           load_ready,
    output logic [6:0]                     led_out,
    output logic [NUM_DIGITS-1:0]          digit_en,
    output logic                           frame_done,
    output state_t                         scan_state
);

    localparam int WORD_W = NIBBLE_W * NUM_DIGITS;
    // Counter holds values up to max(SCAN_DIV, BLANK_CYCLES) - 1; at least 1 bit.
    localparam int CNT_W  = max2(1, $clog2(max2(SCAN_DIV, BLANK_CYCLES)));
    localparam int IDX_W  = max2(1, $clog2(NUM_DIGITS));

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  active;
    logic [WORD_W-1:0]  shadow;
    logic               pending;

    state_t             state_nx;
    logic [IDX_W-1:0]   idx_nx;
    logic [CNT_W-1:0]   cnt_nx;

    logic [NIBBLE_W-1:0]   nibble_sel;
    logic [6:0]            seg_dec;
    logic                  blank_sel;
    logic [6:0]            led_nx;
    logic [NUM_DIGITS-1:0] digit_en_nx;
    logic                  frame_done_nx;
    logic                  xfer;
    logic                  commit;

    assign load_ready = !pending;
    assign scan_state = state;
    assign xfer       = load_valid && load_ready;
    assign commit     = frame_done && pending;

    // ------------------------------------------------------------------
    // Next-state logic for the scan sequence.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt + CNT_W'(1);
        case (state)
            STATE_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nx = STATE_SHOW;
                    cnt_nx   = '0;
                end
            end
            STATE_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nx = STATE_BLANK;
                    cnt_nx   = '0;
                    idx_nx   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end
            default: begin
                state_nx = STATE_BLANK;
                cnt_nx   = '0;
                idx_nx   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are registered, so they are computed from the next index and
    // state. The active word only changes on the frame_done edge, where the
    // next state is always BLANK, so the lit digits always see a stable word.
    // ------------------------------------------------------------------
    always_comb begin
        nibble_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nx == IDX_W'(i)) begin
                nibble_sel = active[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    seg7_decode u_decode (
        .nibble   (nibble_sel),
        .segments (seg_dec)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    // Walking down from the top digit keeps a running "all zero so far" flag.
    logic [NUM_DIGITS-1:0] lead_zero;

    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run && (active[i*NIBBLE_W +: NIBBLE_W] == '0);
            lead_zero[i] = run && (i != 0);
        end
    end

    always_comb begin
        blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nx == IDX_W'(i)) begin
                blank_sel = lead_zero[i];
            end
        end
    end
`else
    assign blank_sel = 1'b0;
`endif

    always_comb begin
        digit_en_nx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_en_nx[i] = (state_nx == STATE_SHOW) && (idx_nx == IDX_W'(i));
        end
    end

    assign led_nx        = ((state_nx == STATE_SHOW) && !blank_sel) ? seg_dec : SEG_BLANK;
    assign frame_done_nx = (state_nx == STATE_SHOW) && (idx_nx == IDX_LAST) &&
                           (cnt_nx == SHOW_LAST);

    // ------------------------------------------------------------------
    // State, outputs, handshake and commit.
    // A transfer needs pending=0 and a commit needs pending=1, so the two
    // never happen on the same edge; a word taken during the frame_done
    // cycle therefore waits for the following frame_done.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= STATE_BLANK;
            idx        <= '0;
            cnt        <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            led_out    <= SEG_BLANK;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            led_out    <= led_nx;
            digit_en   <= digit_en_nx;
            frame_done <= frame_done_nx;
            if (xfer) begin
                shadow  <= load_digits;
                pending <= 1'b1;
            end
            if (commit) begin
                active  <= shadow;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller
// Directed bench for seg7_scan_controller with NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2. Expected segment patterns are written out by hand per test.
// Honors SEG7_LEADING_ZERO_BLANK_EN for the leading-zero expectations.
module tb_seg7_scan_controller;

    localparam int NUM_DIGITS   = 4;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME_LEN    = NUM_DIGITS * (SCAN_DIV + BLANK_CYCLES);

    localparam logic [6:0] P0   = 7'b1111110;
    localparam logic [6:0] P1   = 7'b0110000;
    localparam logic [6:0] P2   = 7'b1101101;
    localparam logic [6:0] P3   = 7'b1111001;
    localparam logic [6:0] P4   = 7'b0110011;
    localparam logic [6:0] P5   = 7'b1011011;
    localparam logic [6:0] POFF = 7'b0000000;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] PLZ  = POFF;
`else
    localparam logic [6:0] PLZ  = P0;
`endif

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic [15:0] load_digits;
    logic        load_ready;
    logic [6:0]  led_out;
    logic [3:0]  digit_en;
    logic        frame_done;
    logic [0:0]  scan_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seg7_scan_controller #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_digits (load_digits),
        .load_ready  (load_ready),
        .led_out     (led_out),
        .digit_en    (digit_en),
        .frame_done  (frame_done),
        .scan_state  (scan_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_frame_done(input string tag);
        for (int i = 0; i < 2 * FRAME_LEN && !frame_done; i++) step();
        check_eq(tag, frame_done, 1'b1);
    endtask

    // Offer one word and hold valid until it transfers, then drop valid.
    task automatic offer(input string tag, input logic [15:0] data);
        load_digits = data;
        load_valid  = 1'b1;
        for (int i = 0; i < 2 * FRAME_LEN && !load_ready; i++) step();
        check_eq({tag, "_ready"}, load_ready, 1'b1);
        step();
        check_eq({tag, "_ready_fall"}, load_ready, 1'b0);
        load_valid = 1'b0;
    endtask

    // Starts while blanking before digit 0; checks each digit's enable,
    // pattern and lit duration, and the frame_done position on digit 3.
    task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp_seg [4];
        int n;
        int fd_at;
        exp_seg = '{e0, e1, e2, e3};
        for (int d = 0; d < NUM_DIGITS; d++) begin
            for (int i = 0; i < 20 && digit_en == 4'b0; i++) step();
            check_eq($sformatf("%s_d%0d_en", tag, d), digit_en, 4'b0001 << d);
            check_eq($sformatf("%s_d%0d_seg", tag, d), led_out, exp_seg[d]);
            n     = 0;
            fd_at = -1;
            while (digit_en != 4'b0 && n < 20) begin
                if (frame_done) fd_at = n;
                step();
                n++;
            end
            check_eq($sformatf("%s_d%0d_len", tag, d), n, SCAN_DIV);
            if (d == NUM_DIGITS - 1)
                check_eq($sformatf("%s_fd_pos", tag), fd_at, SCAN_DIV - 1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rel;
        int t1;
        int t2;
        int stall;
        logic fd_prev;

        reset       = 1'b1;
        load_valid  = 1'b0;
        load_digits = '0;
        repeat (3) step();

        check_eq("rst_led", led_out, 7'b0);
        check_eq("rst_en", digit_en, 4'b0);
        check_eq("rst_fd", frame_done, 1'b0);
        check_eq("rst_ready", load_ready, 1'b1);
        check_eq("rst_state", scan_state, 1'b0);

        // Release: cycle 1 still blanking, digit 0 lit from cycle 2.
        reset = 1'b0;
        rel   = cyc;
        step();
        check_eq("rel_c1_en", digit_en, 4'b0);
        check_eq("rel_c1_state", scan_state, 1'b0);
        step();
        check_eq("rel_c2_en", digit_en, 4'b0001);
        check_eq("rel_c2_seg", led_out, P0);

        // First frame_done lands on cycle NUM_DIGITS*(B+S)-1 after release.
        wait_frame_done("fd1_seen");
        check_eq("fd1_cycle", cyc - rel, FRAME_LEN - 1);
        t1 = cyc;
        step();
        check_eq("fd1_pulse", frame_done, 1'b0);
        wait_frame_done("fd2_seen");
        t2 = cyc;
        check_eq("fd_period", t2 - t1, FRAME_LEN);
        step();
        check_frame("idle", P0, PLZ, PLZ, PLZ);

        // Single load, commit at frame end.
        offer("l1234", 16'h1234);
        wait_frame_done("l1234_fd");
        check_eq("l1234_ready_at_fd", load_ready, 1'b0);
        step();
        check_eq("l1234_ready_rise", load_ready, 1'b1);
        check_frame("w1234", P4, P3, P2, P1);

        // Back-to-back offers with valid held.
        load_digits = 16'h1111;
        load_valid  = 1'b1;
        for (int i = 0; i < 2 * FRAME_LEN && !load_ready; i++) step();
        step();
        check_eq("b2b_first_taken", load_ready, 1'b0);
        load_digits = 16'h2222;
        stall   = 0;
        fd_prev = 1'b0;
        while (!load_ready && stall < 2 * FRAME_LEN) begin
            fd_prev = frame_done;
            step();
            stall++;
        end
        check_eq("b2b_ready_after_fd", {load_ready, fd_prev}, 2'b11);
        step();
        check_eq("b2b_second_taken", load_ready, 1'b0);
        load_valid = 1'b0;
        check_frame("w1111", P1, P1, P1, P1);
        check_frame("w2222", P2, P2, P2, P2);

        // Non-decimal codes decode to blank.
        offer("l0a0f", 16'h0A0F);
        wait_frame_done("l0a0f_fd");
        step();
        check_frame("w0a0f", POFF, P0, POFF, PLZ);

        // Leading zeros.
        offer("l0050", 16'h0050);
        wait_frame_done("l0050_fd");
        step();
        check_frame("w0050", P0, P5, PLZ, PLZ);

        // Reset with a word pending: it is discarded.
        offer("l9999", 16'h9999);
        repeat (5) step();
        check_eq("pre_rst_pending", load_ready, 1'b0);
        reset = 1'b1;
        step();
        check_eq("mid_rst_led", led_out, 7'b0);
        check_eq("mid_rst_en", digit_en, 4'b0);
        check_eq("mid_rst_fd", frame_done, 1'b0);
        check_eq("mid_rst_ready", load_ready, 1'b1);
        reset = 1'b0;
        check_frame("post_rst_a", P0, PLZ, PLZ, PLZ);
        check_frame("post_rst_b", P0, PLZ, PLZ, PLZ);
        check_eq("post_rst_ready", load_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Time-multiplexed scan controller for a multi-digit common-segment seven-segment display. It holds a packed BCD word and cycles one-hot digit enables across NUM_DIGITS digits, driving a single shared 7-bit segment bus. A blanking gap between digits suppresses ghosting. New values are accepted through a valid/ready handshake and committed only at frame boundaries, so a frame never tears. It sits between the seconds/counter logic and the display pins.

## Interface
- NUM_DIGITS, 4: number of digits; legal range 1..8.
- SCAN_DIV, 16000: clock cycles each digit is lit; must be at least 1. The default gives 1 ms at 16 MHz.
- BLANK_CYCLES, 16: all-off cycles before each digit is lit; must be at least 1.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  a new display word is offered.
- load_digits  in  4*NUM_DIGITS  packed BCD word; nibble i drives digit i; digit 0 is least significant.
- load_ready  out  1  the block can accept a word.
- led_out  out  7  segment drive, active-high. Bit 6 is segment a (top), then clockwise; bit 0 is segment g (middle).
- digit_en  out  NUM_DIGITS  one-hot digit enable, active-high; all zero while blanking.
- frame_done  out  1  one-cycle pulse on the last SHOW cycle of digit NUM_DIGITS-1.

## Operation
- Registers:
  - active word: the value being displayed.
  - shadow word: holds an accepted value awaiting commit.
  - pending flag: set while the shadow holds an uncommitted value.
  - digit index.
  - cycle counter, width $clog2(max(SCAN_DIV,BLANK_CYCLES)).
  - state.
- Reset values: state BLANK, index 0, counter 0, active 0, pending 0, led_out 0, digit_en 0, frame_done 0, load_ready 1.
- FSM transitions:
  - BLANK: stays for BLANK_CYCLES cycles, then goes to SHOW.
  - SHOW: stays for SCAN_DIV cycles. It then goes to BLANK, and the index increments, wrapping from NUM_DIGITS-1 to 0.
- Outputs in BLANK: led_out=0 and digit_en=0.
- Outputs in SHOW: digit_en has bit [index] set; led_out=decode(active nibble[index]).
- Decode table (bits a..g):
  - 0→1111110, 1→0110000, 2→1101101, 3→1111001, 4→0110011
  - 5→1011011, 6→1011111, 7→1110000, 8→1111111, 9→1111011
  - 10..15→0000000 (blank).
- Handshake: load_ready = !pending. A transfer occurs when load_valid && load_ready. On transfer, shadow←load_digits and pending←1.
- Commit: on the frame_done cycle with pending=1, active←shadow and pending←0. load_ready is therefore high on the next cycle.
- A transfer in the frame_done cycle itself, which is possible only when pending=0, is committed at the next frame_done, not the current one.
- load_valid may be deasserted at any time without side effects.
- Reset mid-operation returns every register to its reset value. A pending shadow is discarded.

## Timing
- Outputs are registered and change on the same clock edge as the state/index update.
- The first cycle after reset release is in BLANK. digit_en=0001 first appears BLANK_CYCLES cycles after reset release.
- Frame length is exactly NUM_DIGITS*(BLANK_CYCLES+SCAN_DIV) cycles.
- Handshake to display latency:
  - A transfer becomes visible on the first SHOW cycle of digit 0 after the next frame_done.
  - The worst case is one full frame plus BLANK_CYCLES+1 cycles.
- digit_en never has more than one bit set, and is never non-zero in the same cycle that led_out belongs to a different digit.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined:
  - In SHOW, digit i is blanked (led_out=0) when its nibble is 0 and every higher nibble is 0.
  - digit_en is still asserted for that digit.
  - Digit 0 is never blanked, so zero displays as "0".
- SEG7_LEADING_ZERO_BLANK_EN undefined: every digit is decoded as stored. Leading zeros are shown.

## Structure
- Shared package seg7_pkg contains:
  - the segment-pattern constants SEG_0..SEG_9 and SEG_BLANK;
  - the state typedef (BLANK, SHOW);
  - the nibble width constant.
- One sub-module, seg7_decode: a combinational 4-bit to 7-bit decoder implementing the table above. It is instantiated once on the muxed nibble.
- The scan FSM, handshake and leading-zero logic live in seg7_scan_controller.

## Test plan
Default bench parameters: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
- Reset, then idle: all outputs 0 and load_ready=1 during reset. digit_en=0001 appears 2 cycles after release and lasts 8 cycles; the digit_en sequence is 0001,0010,0100,1000; frame_done pulses every 40 cycles.
- Load 0x1234 at cycle 5: load_ready falls next cycle. After frame_done, digit 0 shows 0110011, digit 1 1111001, digit 2 1101101, digit 3 0110000. load_ready rises the cycle after frame_done.
- Back-to-back offers 0x1111 then 0x2222 with load_valid held: the second is stalled (load_ready=0) until the first commits. 0x2222 is displayed one frame after 0x1111.
- Load 0x0A0F: digits 0 and 2 show 0000000 while their digit_en bits are asserted; digit 1 shows 1111110.
- Load 0x0050:
  - With SEG7_LEADING_ZERO_BLANK_EN: digits 3 and 2 are blank, digit 1 shows 1011011, digit 0 shows 1111110.
  - Without SEG7_LEADING_ZERO_BLANK_EN: digits 3 and 2 show 1111110.
- Accept 0x9999, then assert reset for 1 cycle mid-frame before commit: outputs return to reset values, 0x9999 is never displayed, and the display shows 0000.
